// File: rtl/datapath_control_pkg.sv
// Shared definitions for the 4-bit datapath controller: opcodes, instruction
// field positions and FSM state encoding.
package datapath_control_pkg;

  localparam int INSTR_W = 12;

  localparam int OP_MSB  = 11;
  localparam int OP_LSB  = 9;
  localparam int RD_MSB  = 8;
  localparam int RD_LSB  = 7;
  localparam int RS_MSB  = 6;
  localparam int RS_LSB  = 5;
  localparam int CIN_BIT = 4;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_LDI  = 3'b110;
  localparam logic [2:0] OP_NOT  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RDA  = 3'd1,
    ST_RDB  = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4
  } state_t;

  function automatic logic op_is_ldi(input logic [2:0] op);
    return (op == OP_LDI);
  endfunction

endpackage

// File: rtl/datapath_control_instr_decode.sv
// Combinational decode of the latched instruction's op and carry-enable
// fields into op class, carry usage and ALU select.
module instr_decode
  import datapath_control_pkg::*;
(
  input  logic [2:0] op,
  input  logic       cin_en,
  output logic       is_ldi,
  output logic       uses_carry,
  output logic       cin_used,
  output logic [2:0] alu_sel
);

  assign is_ldi     = op_is_ldi(op);
  assign uses_carry = (op == OP_ADD) || (op == OP_SUB);
  // Only chained add/subtract may see the stored flag as carry-in.
  assign cin_used   = uses_carry & cin_en;
  assign alu_sel    = op;

endmodule

// File: rtl/datapath_control.sv
// Multi-cycle controller for the 4-bit datapath: sequences register reads,
// operand loads, ALU select and write-back, and holds the carry/borrow flag.
module datapath_control
  import datapath_control_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        ula_cb_out,
  output logic [1:0]  rf_addr,
  output logic        rf_we,
  output logic        opa_we,
  output logic        opb_we,
  output logic [2:0]  ula_sel,
  output logic        ula_cb_in,
  output logic        wb_sel,
  output logic [3:0]  imm_out,
  output logic        carry_flag,
  output logic        done
);

  state_t                state_r;
  state_t                state_next_s;
  logic [INSTR_W-1:0]    instr_r;
  logic                  carry_flag_r;
  logic                  is_ldi_s;
  logic                  uses_carry_s;
  logic                  cin_used_s;
  logic [2:0]            alu_sel_s;
  logic                  accept_s;

  instr_decode u_decode (
    .op         (instr_r[OP_MSB:OP_LSB]),
    .cin_en     (instr_r[CIN_BIT]),
    .is_ldi     (is_ldi_s),
    .uses_carry (uses_carry_s),
    .cin_used   (cin_used_s),
    .alu_sel    (alu_sel_s)
  );

  assign accept_s   = (state_r == ST_IDLE) && instr_valid;
  assign imm_out    = instr_r[IMM_MSB:IMM_LSB];
  assign carry_flag = carry_flag_r;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Instruction latch: loaded only on acceptance, frozen until IDLE returns
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_r <= '0;
    end else if (accept_s) begin
      instr_r <= instr;
    end else begin
      instr_r <= instr_r;
    end
  end

  // Carry/borrow flag: updated on the same edge that commits an ADD/SUB write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_flag_r <= 1'b0;
    end else if ((state_r == ST_WB) && uses_carry_s) begin
      carry_flag_r <= ula_cb_out;
    end else begin
      carry_flag_r <= carry_flag_r;
    end
  end

  // Next-state and control-output decode from state and latched instruction
  always_comb begin
    state_next_s = ST_IDLE;
    instr_ready  = 1'b0;
    rf_addr      = 2'd0;
    rf_we        = 1'b0;
    opa_we       = 1'b0;
    opb_we       = 1'b0;
    ula_sel      = 3'd0;
    ula_cb_in    = 1'b0;
    wb_sel       = 1'b0;
    done         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        instr_ready = 1'b1;
        // LDI skips the operand reads since the ALU is bypassed.
        if (instr_valid) begin
          state_next_s = op_is_ldi(instr[OP_MSB:OP_LSB]) ? ST_WB : ST_RDA;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RDA: begin
        rf_addr      = instr_r[RD_MSB:RD_LSB];
        state_next_s = ST_RDB;
      end
      ST_RDB: begin
        rf_addr      = instr_r[RS_MSB:RS_LSB];
        opa_we       = 1'b1;
        state_next_s = ST_EXEC;
      end
      ST_EXEC: begin
        rf_addr      = instr_r[RS_MSB:RS_LSB];
        opb_we       = 1'b1;
        state_next_s = ST_WB;
      end
      ST_WB: begin
        rf_addr      = instr_r[RD_MSB:RD_LSB];
        rf_we        = 1'b1;
        done         = 1'b1;
        ula_sel      = alu_sel_s;
        ula_cb_in    = carry_flag_r & cin_used_s;
        wb_sel       = is_ldi_s;
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_datapath_control.sv
// Directed self-checking bench for datapath_control with hand-computed
// expected control vectors per cycle.
module tb_datapath_control;

  logic        clk;
  logic        rst;
  logic [11:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        ula_cb_out;
  logic [1:0]  rf_addr;
  logic        rf_we;
  logic        opa_we;
  logic        opb_we;
  logic [2:0]  ula_sel;
  logic        ula_cb_in;
  logic        wb_sel;
  logic [3:0]  imm_out;
  logic        carry_flag;
  logic        done;

  int          n_checks;
  int          n_fail;
  logic        watch_we;
  logic        saw_we;
  logic [11:0] ctrl;

  datapath_control dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .ula_cb_out  (ula_cb_out),
    .rf_addr     (rf_addr),
    .rf_we       (rf_we),
    .opa_we      (opa_we),
    .opb_we      (opb_we),
    .ula_sel     (ula_sel),
    .ula_cb_in   (ula_cb_in),
    .wb_sel      (wb_sel),
    .imm_out     (imm_out),
    .carry_flag  (carry_flag),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ctrl = {instr_ready, rf_we, opa_we, opb_we, done, wb_sel, rf_addr, ula_sel, ula_cb_in};

  // Track any write strobe while the reset-abort scenario is armed
  always @(posedge clk) begin
    if (watch_we && rf_we) saw_we <= 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] cv(input logic rdy, input logic we, input logic oa,
                                     input logic ob, input logic dn, input logic wbs,
                                     input logic [1:0] a, input logic [2:0] sel, input logic cb);
    return {rdy, we, oa, ob, dn, wbs, a, sel, cb};
  endfunction

  function automatic logic [11:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs, input logic cin, input logic [3:0] imm);
    return {op, rd, rs, cin, imm};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [11:0] w);
    instr       = w;
    instr_valid = 1'b1;
    cyc();
    instr_valid = 1'b0;
  endtask

  task automatic run_ldi(input string tag, input logic [1:0] rd, input logic [3:0] imm);
    issue(mk(3'b110, rd, 2'd0, 1'b0, imm));
    check_eq({tag, "_wb"}, {4'd0, ctrl}, {4'd0, cv(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, rd, 3'b110, 1'b0)});
    check_eq({tag, "_imm"}, {12'd0, imm_out}, {12'd0, imm});
    cyc();
    check_eq({tag, "_ready"}, {4'd0, ctrl}, {4'd0, 12'h800});
  endtask

  task automatic run_alu(input string tag, input logic [2:0] op, input logic [1:0] rd,
                         input logic [1:0] rs, input logic cin, input logic alu_cb,
                         input logic exp_cb_in, input logic exp_flag);
    issue(mk(op, rd, rs, cin, 4'h0));
    check_eq({tag, "_rda"}, {4'd0, ctrl}, {4'd0, cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rd, 3'd0, 1'b0)});
    cyc();
    check_eq({tag, "_rdb"}, {4'd0, ctrl}, {4'd0, cv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, rs, 3'd0, 1'b0)});
    cyc();
    check_eq({tag, "_exec"}, {4'd0, ctrl}, {4'd0, cv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, rs, 3'd0, 1'b0)});
    cyc();
    ula_cb_out = alu_cb;
    check_eq({tag, "_wb"}, {4'd0, ctrl}, {4'd0, cv(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, rd, op, exp_cb_in)});
    cyc();
    ula_cb_out = 1'b0;
    check_eq({tag, "_ready"}, {4'd0, ctrl}, {4'd0, 12'h800});
    check_eq({tag, "_flag"}, {15'd0, carry_flag}, {15'd0, exp_flag});
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    watch_we    = 1'b0;
    saw_we      = 1'b0;
    rst         = 1'b1;
    instr       = 12'd0;
    instr_valid = 1'b0;
    ula_cb_out  = 1'b0;

    #3;
    check_eq("rst_ctrl", {4'd0, ctrl}, {4'd0, 12'h800});
    check_eq("rst_imm", {12'd0, imm_out}, 16'd0);
    check_eq("rst_flag", {15'd0, carry_flag}, 16'd0);
    cyc();
    rst = 1'b0;
    cyc();

    run_ldi("ldi_r2", 2'd2, 4'hA);
    run_ldi("ldi_r0", 2'd0, 4'hF);
    run_ldi("ldi_r1", 2'd1, 4'h1);

    // R0=F + R1=1 carries out of the ALU.
    run_alu("add_c0", 3'b000, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1);
    // AND must neither see nor touch the flag.
    run_alu("and_iso", 3'b010, 2'd2, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    run_alu("add_c1", 3'b000, 2'd0, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    // rd == rs, SUB borrow sets the flag.
    run_alu("sub_same", 3'b001, 2'd3, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1);

    // Back-to-back: XOR r1,r2 then OR r3,r0 with valid held high.
    instr       = mk(3'b100, 2'd1, 2'd2, 1'b0, 4'h0);
    instr_valid = 1'b1;
    check_eq("b2b_c0", {4'd0, ctrl}, {4'd0, 12'h800});
    cyc();
    instr = mk(3'b011, 2'd3, 2'd0, 1'b1, 4'h5);
    check_eq("b2b_c1", {4'd0, ctrl}, {4'd0, cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0, 1'b0)});
    cyc();
    check_eq("b2b_c2", {4'd0, ctrl}, {4'd0, cv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 3'd0, 1'b0)});
    cyc();
    check_eq("b2b_c3", {4'd0, ctrl}, {4'd0, cv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 3'd0, 1'b0)});
    cyc();
    check_eq("b2b_c4", {4'd0, ctrl}, {4'd0, cv(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 3'b100, 1'b0)});
    cyc();
    check_eq("b2b_c5", {4'd0, ctrl}, {4'd0, 12'h800});
    cyc();
    instr_valid = 1'b0;
    check_eq("b2b_c6", {4'd0, ctrl}, {4'd0, cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 3'd0, 1'b0)});
    cyc();
    cyc();
    cyc();
    check_eq("b2b_c9", {4'd0, ctrl}, {4'd0, cv(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 3'b011, 1'b0)});
    cyc();
    check_eq("b2b_c10", {4'd0, ctrl}, {4'd0, 12'h800});

    // Reset asserted mid-cycle during EXEC of SUB r3,r1 with the flag set.
    watch_we = 1'b1;
    issue(mk(3'b001, 2'd3, 2'd1, 1'b1, 4'h7));
    cyc();
    cyc();
    check_eq("rstx_exec", {4'd0, ctrl}, {4'd0, cv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 3'd0, 1'b0)});
    #2;
    rst = 1'b1;
    #1;
    check_eq("rstx_ctrl", {4'd0, ctrl}, {4'd0, 12'h800});
    check_eq("rstx_flag", {15'd0, carry_flag}, 16'd0);
    check_eq("rstx_imm", {12'd0, imm_out}, 16'd0);
    cyc();
    rst = 1'b0;
    cyc();
    check_eq("rstx_idle", {4'd0, ctrl}, {4'd0, 12'h800});
    cyc();
    check_eq("rstx_no_we", {15'd0, saw_we}, 16'd0);
    watch_we = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/datapath_control.md
# datapath_control

Multi-cycle control unit that sits directly upstream of the 4-bit datapath: the register file, the operand registers, the ALU and the write-back mux. It accepts 12-bit instructions over a valid/ready handshake and sequences register-file reads, operand latching, ALU operation select and write-back. It also holds the carry/borrow flag used for chained add/subtract. It is combinationally in the datapath's control path and purely sequential in its own state.

## Interface
- Parameters: none; the 4-bit data width and 2-bit register address are fixed.
- Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instr` in 12: instruction word. Fields:
  - `[11:9]` op
  - `[8:7]` rd
  - `[6:5]` rs
  - `[4]` cin_en
  - `[3:0]` imm
- `instr_valid` in 1: instruction present.
- `instr_ready` out 1: controller can accept an instruction.
- `ula_cb_out` in 1: carry/borrow from the ALU.
- `rf_addr` out 2: register-file address.
- `rf_we` out 1: register-file write enable.
- `opa_we` out 1: operand-A register load enable.
- `opb_we` out 1: operand-B register load enable.
- `ula_sel` out 3: ALU operation select.
- `ula_cb_in` out 1: ALU carry/borrow in.
- `wb_sel` out 1: write-back mux select; 0 = ALU result, 1 = `imm_out`.
- `imm_out` out 4: latched immediate.
- `carry_flag` out 1: stored carry/borrow.
- `done` out 1: one-cycle pulse on the write-back cycle.

## Operation
- Opcodes:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 XNOR, 111 NOT: `ula_sel` = op.
  - 110 LDI: rd ← imm. The ALU is not used.
- Register file reads synchronously: `data_out` reflects `rf_addr` one edge later.
- FSM states: IDLE, RDA, RDB, EXEC, WB.
  - IDLE: `instr_ready`=1. On `instr_valid`, latch `instr` and go to WB if op=LDI, else to RDA.
  - RDA: `rf_addr`=rd. Next state RDB.
  - RDB: `rf_addr`=rs, `opa_we`=1 (operand A captures rd). Next state EXEC.
  - EXEC: `rf_addr`=rs, `opb_we`=1 (operand B captures rs). Next state WB.
  - WB: `rf_addr`=rd, `rf_we`=1, `done`=1, `ula_sel`=op, `wb_sel`=(op==LDI). Next state IDLE.
- NOT uses operand A (rd) only. It still traverses RDB and EXEC; the operand-B load is harmless.
- Carry handling:
  - `ula_cb_in` = `carry_flag` & cin_en, only when op is ADD or SUB; 0 otherwise.
  - In WB of ADD or SUB, `carry_flag` ← `ula_cb_out`.
  - All other ops leave `carry_flag` unchanged.
- The latched instruction is held constant from acceptance until IDLE is re-entered. `instr` changes after acceptance are ignored.
- All control outputs are decoded from the state register and the latched instruction. Outside their active states they are 0.

## Timing
- Reset values:
  - state = IDLE; latched instruction = 0; `carry_flag`=0.
  - `instr_ready`=1. `rf_we`, `opa_we`, `opb_we`, `done`, `wb_sel` = 0.
  - `rf_addr`=0, `ula_sel`=0, `ula_cb_in`=0, `imm_out`=0.
- ALU instruction, accepted in cycle 0:
  - RDA in cycle 1, RDB in cycle 2, EXEC in cycle 3, WB in cycle 4.
  - The write is committed at the end of cycle 4.
  - `instr_ready` is high again in cycle 5, so throughput is 1 instruction per 5 cycles.
- LDI accepted in cycle 0: WB in cycle 1, `instr_ready` in cycle 2.
- `instr_ready` is low in every non-IDLE state. `instr_valid` in those states is not consumed.
- rd == rs is legal. Both operands carry the same register value.
- `rst` asserted mid-instruction:
  - Outputs go to their reset values immediately, without waiting for a clock edge.
  - A WB in progress does not write; `rf_we` falls with `rst`.
  - `carry_flag` is cleared.
- The `carry_flag` update and the register-file write take effect on the same edge (end of WB).

## Structure
- Shared package holds:
  - opcode constants: OP_ADD … OP_NOT, OP_LDI = 3'b110;
  - instruction field bit positions;
  - FSM state encoding.
- One combinational sub-module, `instr_decode`. It takes the latched instruction and produces op class (ALU / LDI), `uses_carry` and the ALU select.
- The FSM, instruction latch and `carry_flag` stay in `datapath_control`.

## Test plan
- Reset check: assert `rst` → all outputs at their reset values, `instr_ready`=1.
- LDI: LDI rd=2, imm=4'hA → `rf_we`=1, `rf_addr`=2, `wb_sel`=1, `imm_out`=A in cycle 1; `instr_ready`=1 in cycle 2.
- ADD with carry-in:
  - Setup: R0=4'hF, R1=4'h1, cin_en=0.
  - Stimulus: ADD rd=0, rs=1.
  - Required: `opa_we` in cycle 2, `opb_we` in cycle 3; WB in cycle 4 with `ula_sel`=000, `rf_we`=1, `done`=1; `carry_flag`=1 afterwards.
  - Follow-up: ADD with cin_en=1 → `ula_cb_in`=1 during WB.
- Flag isolation: AND after a carry-producing ADD → `ula_cb_in`=0 and `carry_flag` remains 1.
- Back-to-back: `instr_valid` held high with two queued instructions → the second is accepted exactly in cycle 5; `instr` changes during cycles 1–4 do not alter `rf_addr`/`ula_sel`.
- Reset during EXEC of SUB rd=3 → `rf_we` never asserts, `carry_flag`=0, state IDLE, `instr_ready`=1 immediately.
